// File: rtl/bp_be_dcache_data_mem_arbiter.sv
// Per-cycle arbiter for the single-ported D$ data memory (LCE, load, write-buffer drain),
// with a saturating starvation counter for the wbuf head and a fence drain sequencer.
module bp_be_dcache_data_mem_arbiter #(
  parameter int starve_limit_p = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,

  input  logic       lce_v_i,
  output logic       lce_yumi_o,

  input  logic       ld_v_i,
  output logic       ld_ready_o,
  output logic       ld_data_v_o,

  input  logic       wbuf_v_i,
  input  logic       wbuf_empty_i,
  output logic       wbuf_yumi_o,

  input  logic       fence_v_i,
  output logic       fence_done_o,

  output logic       data_mem_v_o,
  output logic [1:0] data_mem_src_o
);

  localparam logic [3:0] lp_starve_limit = 4'(starve_limit_p);

  localparam logic [1:0] lp_src_none = 2'd0;
  localparam logic [1:0] lp_src_lce  = 2'd1;
  localparam logic [1:0] lp_src_ld   = 2'd2;
  localparam logic [1:0] lp_src_wbuf = 2'd3;

  typedef enum logic [1:0] {
    e_run   = 2'd0,
    e_drain = 2'd1,
    e_done  = 2'd2
  } state_e;

  state_e     r_state;
  logic [3:0] r_starve;
  logic       r_ld_data_v;
  logic       r_fence_done;

  logic       w_starved;
  logic       w_ld_allowed;
  logic       w_lce_gnt;
  logic       w_ld_gnt;
  logic       w_wbuf_gnt;
  logic [3:0] w_starve_next;

  assign w_starved    = (r_starve == lp_starve_limit);
  // Loads are held off from the very cycle a fence is raised until the fence completes.
  assign w_ld_allowed = (r_state == e_run) & ~fence_v_i;

  // Grants are forced low while reset is asserted so outputs clear asynchronously.
  always_comb begin
    w_lce_gnt  = 1'b0;
    w_ld_gnt   = 1'b0;
    w_wbuf_gnt = 1'b0;
    if (!reset_i) begin
      if (lce_v_i) begin
        w_lce_gnt = 1'b1;
      end else if (wbuf_v_i && w_starved) begin
        w_wbuf_gnt = 1'b1;
      end else if (ld_v_i && w_ld_allowed) begin
        w_ld_gnt = 1'b1;
      end else if (wbuf_v_i) begin
        w_wbuf_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    w_starve_next = 4'd0;
    if (w_wbuf_gnt) begin
      w_starve_next = 4'd0;
    end else if (wbuf_v_i) begin
      w_starve_next = (r_starve >= lp_starve_limit) ? lp_starve_limit : (r_starve + 4'd1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= e_run;
      r_starve     <= 4'd0;
      r_ld_data_v  <= 1'b0;
      r_fence_done <= 1'b0;
    end else begin
      r_starve     <= w_starve_next;
      r_ld_data_v  <= w_ld_gnt;
      r_fence_done <= 1'b0;
      case (r_state)
        e_run: begin
          if (fence_v_i) begin
            r_state <= e_drain;
          end
        end
        // A dropped fence_v_i does not abort the drain; only an empty buffer ends it.
        e_drain: begin
          if (wbuf_empty_i && !wbuf_v_i) begin
            r_state      <= e_done;
            r_fence_done <= 1'b1;
          end
        end
        e_done: begin
          r_state <= e_run;
        end
        default: begin
          r_state <= e_run;
        end
      endcase
    end
  end

  assign lce_yumi_o   = w_lce_gnt;
  assign ld_ready_o   = w_ld_gnt;
  assign wbuf_yumi_o  = w_wbuf_gnt;
  assign data_mem_v_o = w_lce_gnt | w_ld_gnt | w_wbuf_gnt;
  assign ld_data_v_o  = r_ld_data_v;
  assign fence_done_o = r_fence_done;

  always_comb begin
    data_mem_src_o = lp_src_none;
    if (w_lce_gnt) begin
      data_mem_src_o = lp_src_lce;
    end else if (w_ld_gnt) begin
      data_mem_src_o = lp_src_ld;
    end else if (w_wbuf_gnt) begin
      data_mem_src_o = lp_src_wbuf;
    end
  end

endmodule

// File: tb/tb_bp_be_dcache_data_mem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural
// model of the arbitration rules, with a counting model of the write buffer occupancy.
module tb_bp_be_dcache_data_mem_arbiter;

  localparam int LIMIT = 4;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       lce_v_i = 1'b0;
  logic       lce_yumi_o;
  logic       ld_v_i = 1'b0;
  logic       ld_ready_o;
  logic       ld_data_v_o;
  logic       wbuf_v_i = 1'b0;
  logic       wbuf_empty_i = 1'b1;
  logic       wbuf_yumi_o;
  logic       fence_v_i = 1'b0;
  logic       fence_done_o;
  logic       data_mem_v_o;
  logic [1:0] data_mem_src_o;

  bp_be_dcache_data_mem_arbiter #(.starve_limit_p(LIMIT)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .lce_v_i       (lce_v_i),
    .lce_yumi_o    (lce_yumi_o),
    .ld_v_i        (ld_v_i),
    .ld_ready_o    (ld_ready_o),
    .ld_data_v_o   (ld_data_v_o),
    .wbuf_v_i      (wbuf_v_i),
    .wbuf_empty_i  (wbuf_empty_i),
    .wbuf_yumi_o   (wbuf_yumi_o),
    .fence_v_i     (fence_v_i),
    .fence_done_o  (fence_done_o),
    .data_mem_v_o  (data_mem_v_o),
    .data_mem_src_o(data_mem_src_o)
  );

  always #5 clk_i = ~clk_i;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: write-buffer occupancy, denied-cycle count, fence phase, last grant.
  int wb_cnt = 0;
  int m_wait = 0;
  int m_phase = 0;  // 0 normal, 1 waiting for buffer empty, 2 completion cycle
  bit m_ld_data_v = 1'b0;

  int obs_src;
  bit obs_ld_ready;
  bit obs_done;
  bit obs_ld_data_v;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_lce_yumi"}, 32'(lce_yumi_o), 0);
    check_eq({tag, "_ld_ready"}, 32'(ld_ready_o), 0);
    check_eq({tag, "_wbuf_yumi"}, 32'(wbuf_yumi_o), 0);
    check_eq({tag, "_mem_v"}, 32'(data_mem_v_o), 0);
    check_eq({tag, "_src"}, 32'(data_mem_src_o), 0);
    check_eq({tag, "_ld_data_v"}, 32'(ld_data_v_o), 0);
    check_eq({tag, "_fence_done"}, 32'(fence_done_o), 0);
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input bit lce, input bit ld, input bit push, input bit fence);
    int  e_src;
    bit  wv;
    bit  ld_ok;
    int  ngrant;
    @(negedge clk_i);
    wv           = (wb_cnt > 0);
    lce_v_i      = lce;
    ld_v_i       = ld;
    fence_v_i    = fence;
    wbuf_v_i     = wv;
    wbuf_empty_i = !wv;
    #1;
    ld_ok = (m_phase == 0) && !fence;
    if (lce)                         e_src = 1;
    else if (wv && m_wait == LIMIT)  e_src = 3;
    else if (ld && ld_ok)            e_src = 2;
    else if (wv)                     e_src = 3;
    else                             e_src = 0;
    ngrant = int'(lce_yumi_o) + int'(ld_ready_o) + int'(wbuf_yumi_o);
    check_eq("src", 32'(data_mem_src_o), 32'(e_src));
    check_eq("lce_yumi", 32'(lce_yumi_o), 32'(e_src == 1));
    check_eq("ld_ready", 32'(ld_ready_o), 32'(e_src == 2));
    check_eq("wbuf_yumi", 32'(wbuf_yumi_o), 32'(e_src == 3));
    check_eq("mem_v", 32'(data_mem_v_o), 32'(e_src != 0));
    check_eq("one_grant", 32'(ngrant <= 1), 1);
    check_eq("ld_data_v", 32'(ld_data_v_o), 32'(m_ld_data_v));
    check_eq("fence_done", 32'(fence_done_o), 32'(m_phase == 2));
    obs_src       = int'(data_mem_src_o);
    obs_ld_ready  = ld_ready_o;
    obs_done      = fence_done_o;
    obs_ld_data_v = ld_data_v_o;
    @(posedge clk_i);
    m_ld_data_v = (e_src == 2);
    if (e_src == 3)  m_wait = 0;
    else if (wv)     m_wait = (m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1;
    else             m_wait = 0;
    case (m_phase)
      0: if (fence) m_phase = 1;
      1: if (!wv) m_phase = 2;
      default: m_phase = 0;
    endcase
    if (e_src == 3) wb_cnt--;
    if (push) wb_cnt++;
  endtask

  task automatic drain_wbuf();
    for (int k = 0; k < 20 && wb_cnt > 0; k++) step(0, 0, 0, 0);
    check_eq("drain_empty", 32'(wb_cnt), 0);
    step(0, 0, 0, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_starve [6];
    int yumis;
    int done_k;
    bit ld_seen;
    bit fence_req;
    bit r_lce;
    bit r_ld;
    bit r_push;

    // Power-on reset
    repeat (2) @(negedge clk_i);
    check_all_zero("por");
    reset_i = 1'b0;

    // Load-only: granted now, data valid next cycle
    step(0, 1, 0, 0);
    check_eq("ld_only_src", 32'(obs_src), 2);
    step(0, 0, 0, 0);
    check_eq("ld_only_data_v", 32'(obs_ld_data_v), 1);

    // Starvation: loads every cycle, wbuf head waits LIMIT cycles then drains
    exp_starve = '{2, 2, 2, 2, 3, 2};
    wb_cnt = 2;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 0);
      check_eq($sformatf("starve_c%0d", i), 32'(obs_src), 32'(exp_starve[i]));
    end
    drain_wbuf();

    // LCE beats a saturated wbuf; wbuf wins as soon as LCE drops
    wb_cnt = 2;
    for (int i = 0; i < LIMIT; i++) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    check_eq("lce_over_starved", 32'(obs_src), 1);
    step(0, 1, 0, 0);
    check_eq("wbuf_after_lce", 32'(obs_src), 3);
    drain_wbuf();

    // Fence with two buffered stores and loads requested throughout
    wb_cnt = 2;
    step(0, 1, 0, 1);
    check_eq("fence_blocks_ld", 32'(obs_ld_ready), 0);
    yumis = (obs_src == 3) ? 1 : 0;
    ld_seen = 1'b0;
    done_k = -1;
    for (int k = 0; k < 20 && done_k < 0; k++) begin
      step(0, 1, 0, 1);
      if (obs_ld_ready) ld_seen = 1'b1;
      if (obs_src == 3) yumis++;
      if (obs_done) done_k = k;
    end
    check_eq("fence2_ld_blocked", 32'(ld_seen), 0);
    check_eq("fence2_drains", 32'(yumis), 2);
    check_eq("fence2_done_cycle", 32'(done_k), 2);
    step(0, 1, 0, 0);
    check_eq("fence2_ld_resume", 32'(obs_src), 2);
    step(0, 0, 0, 0);

    // Fence on empty buffer, released during drain: pulse exactly 2 cycles later
    step(0, 0, 0, 1);
    check_eq("fence0_c0", 32'(obs_done), 0);
    step(0, 0, 0, 0);
    check_eq("fence0_c1", 32'(obs_done), 0);
    step(0, 0, 0, 0);
    check_eq("fence0_c2", 32'(obs_done), 1);
    step(0, 0, 0, 0);
    check_eq("fence0_c3", 32'(obs_done), 0);

    // Asynchronous reset mid-cycle with every request high
    step(0, 1, 0, 0);
    @(negedge clk_i);
    lce_v_i = 1'b1; ld_v_i = 1'b1; wbuf_v_i = 1'b1; wbuf_empty_i = 1'b0; fence_v_i = 1'b1;
    #1;
    check_eq("pre_rst_ld_data_v", 32'(ld_data_v_o), 1);
    #1;
    reset_i = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(posedge clk_i);
    @(negedge clk_i);
    lce_v_i = 1'b0; ld_v_i = 1'b0; wbuf_v_i = 1'b0; wbuf_empty_i = 1'b1; fence_v_i = 1'b0;
    reset_i = 1'b0;
    wb_cnt = 0; m_wait = 0; m_phase = 0; m_ld_data_v = 1'b0;
    step(0, 1, 0, 0);
    check_eq("post_rst_ld_src", 32'(obs_src), 2);
    step(0, 0, 0, 0);
    check_eq("post_rst_ld_data_v", 32'(obs_ld_data_v), 1);

    // Randomized traffic against the model
    fence_req = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      r_lce = ($urandom_range(0, 3) == 0);
      r_ld  = ($urandom_range(0, 1) == 1);
      if (!fence_req && $urandom_range(0, 39) == 0) fence_req = 1'b1;
      else if (fence_req && m_phase == 1 && $urandom_range(0, 9) == 0) fence_req = 1'b0;
      r_push = !fence_req && (wb_cnt < 8) && ($urandom_range(0, 2) == 0);
      step(r_lce, r_ld, r_push, fence_req);
      if (obs_done) fence_req = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bp_be_dcache_data_mem_arbiter.md
# bp_be_dcache_data_mem_arbiter

Per-cycle arbiter and sequencer for the single-ported D$ data memory, shared by the load pipeline, LCE fill/evict traffic, and write-buffer drain. Sits between the D$ pipeline, the write buffer (drives its `yumi_i`), and the data memory enable/write controls. Enforces a bounded drain latency for buffered stores via a starvation counter, and sequences fences by blocking loads until the write buffer is empty.

## Interface
Parameters:
- `starve_limit_p`, 4, consecutive cycles a valid wbuf head may be denied before it gets priority over loads; legal range 1..15.

Ports:
- `clk_i`  in  1  clock; all state updates on posedge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `lce_v_i`  in  1  LCE requests the data memory this cycle (fill write or evict read).
- `lce_yumi_o`  out  1  LCE request granted this cycle.
- `ld_v_i`  in  1  load pipeline requests a data memory read this cycle.
- `ld_ready_o`  out  1  load granted this cycle.
- `ld_data_v_o`  out  1  registered; read data for the granted load is valid this cycle.
- `wbuf_v_i`  in  1  write-buffer head valid (wbuf `v_o`).
- `wbuf_empty_i`  in  1  write buffer holds no entries (wbuf `empty_o`).
- `wbuf_yumi_o`  out  1  head drained into data memory this cycle (to wbuf `yumi_i`).
- `fence_v_i`  in  1  fence request; held high until `fence_done_o`.
- `fence_done_o`  out  1  one-cycle pulse: all prior stores written.
- `data_mem_v_o`  out  1  data memory enable.
- `data_mem_src_o`  out  2  granted source: 0 none, 1 LCE, 2 load, 3 wbuf.

## Operation
- Grants are combinational from current inputs and state; at most one of `lce_yumi_o`, `ld_ready_o`, `wbuf_yumi_o` high per cycle. `data_mem_v_o` = OR of the three grants.
- Priority in RUN: LCE > wbuf if `starve_q == starve_limit_p` > load > wbuf.
- Starvation counter `starve_q` (4 bits): if `wbuf_yumi_o` then 0; else if `wbuf_v_i` then min(`starve_q`+1, `starve_limit_p`); else 0. Saturates, never wraps.
- `ld_data_v_o` <= `ld_ready_o` (1-cycle read latency).
- FSM states:
  - RUN: normal priority. `fence_v_i` -> DRAIN.
  - DRAIN: `ld_ready_o` = 0; priority LCE > wbuf. Exit to DONE when `wbuf_empty_i` & ~`wbuf_v_i`. `fence_v_i` dropping mid-DRAIN does not abort; drain completes.
  - DONE: `fence_done_o` = 1 for exactly this cycle; loads still blocked; -> RUN unconditionally.
- Fence with already-empty wbuf: RUN -> DRAIN -> DONE, `fence_done_o` 2 cycles after `fence_v_i` first seen.
- Upstream holds stores back while `fence_v_i` high; a `wbuf_v_i` arriving in DRAIN is drained before exit regardless.

## Timing
- Reset (async assert, sync deassert): state RUN, `starve_q` 0, `ld_data_v_o` 0, `fence_done_o` 0. Combinational outputs 0 when all request inputs are 0.
- Reset mid-DRAIN: returns to RUN immediately, no `fence_done_o` pulse.
- Grant outputs valid same cycle as requests; no input-to-registered-output path except `ld_data_v_o`, state, `starve_q`.
- Worst-case wbuf head wait with loads every cycle and no LCE: `starve_limit_p` denied cycles, drained on cycle `starve_limit_p`+1. LCE traffic can extend this unboundedly (LCE always wins).
- Simultaneous LCE, load, wbuf with `starve_q` saturated: LCE granted, counter stays at limit, wbuf granted next cycle if LCE drops.

## Test plan
- Reset: assert `reset_i` mid-cycle with all requests high -> all outputs 0 asynchronously; after release, load-only request -> `ld_ready_o`=1, `data_mem_src_o`=2, `ld_data_v_o`=1 next cycle.
- Starvation, limit 4: `ld_v_i`, `wbuf_v_i` held high -> loads granted cycles 0-3, `wbuf_yumi_o`=1 cycle 4, counter 0, load granted cycle 5.
- LCE priority: all three valid with `starve_q`=4 -> `lce_yumi_o`=1 only; drop `lce_v_i` -> `wbuf_yumi_o`=1.
- Fence with 2 wbuf entries, loads requested throughout -> `ld_ready_o`=0 from fence cycle, two drains, `fence_done_o` pulses once the cycle after empty, loads resume following cycle.
- Fence on empty wbuf -> `fence_done_o` exactly 2 cycles after `fence_v_i`; `fence_v_i` released in DRAIN -> pulse still occurs.
- Mutual exclusion: randomized requests 10k cycles -> never more than one grant high; `data_mem_src_o` consistent with grant.
